// File: rtl/tournament_selector.sv
// tournament_selector: PC-indexed tournament chooser for the branch predictor.
// Each table entry holds one saturating rank counter per component predictor.
// The component with the highest rank wins, and a tie goes to the lowest
// component number. Training comes from the resolve stage through a
// one-entry stage register. That stage is bypassed to lookups that hit its
// index.
//
// Handshake: there is no backpressure. Lookups are purely combinational.
// An update is accepted on any rising edge where upd_valid=1 and ready=1.
// Updates presented while ready=0 are discarded.
module tournament_selector #(
  parameter int NUM_PRED = 3,
  parameter int RANK_W   = 2,
  parameter int INDEX_W  = 6,
  localparam int SEL_W   = (NUM_PRED > 2) ? $clog2(NUM_PRED) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] lookup_index,
  input  logic [NUM_PRED-1:0] lookup_preds,
  output logic               choice,
  output logic [SEL_W-1:0]   choice_sel,
  output logic               ready,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic [NUM_PRED-1:0] upd_preds,
  input  logic               upd_outcome
);

  localparam int DEPTH = 1 << INDEX_W;
  localparam logic [RANK_W-1:0] RANK_MID = RANK_W'(1 << (RANK_W - 1));
  localparam logic [RANK_W-1:0] RANK_MAX = {RANK_W{1'b1}};
  localparam logic [INDEX_W-1:0] PTR_LAST = INDEX_W'(DEPTH - 1);

  typedef logic [NUM_PRED-1:0][RANK_W-1:0] entry_t;
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam entry_t ENTRY_MID = {NUM_PRED{RANK_MID}};

  state_e               state_q;
  logic [INDEX_W-1:0]   ptr_q;
  logic                 ready_q;
  logic                 stg_valid_q;
  logic [INDEX_W-1:0]   stg_index_q;
  logic [NUM_PRED-1:0]  stg_preds_q;
  logic                 stg_outcome_q;

  entry_t tbl_q [DEPTH];

  entry_t               stg_cur;
  entry_t               stg_next;
  logic [NUM_PRED-1:0]  corr;
  logic                 discrim;
  entry_t               sel_ranks;
  logic [RANK_W-1:0]    best_rank;
  logic [SEL_W-1:0]     win_sel;
  logic                 win_pred;

  // Next ranks for the staged update. This reads the table after any
  // earlier write has landed, so back-to-back updates to one index stay exact.
  always_comb begin
    stg_cur  = tbl_q[stg_index_q];
    corr     = ~(stg_preds_q ^ {NUM_PRED{stg_outcome_q}});
    discrim  = (corr != '0) && (corr != '1);
    stg_next = stg_cur;
    if (discrim) begin
      for (int i = 0; i < NUM_PRED; i++) begin
        if (corr[i]) begin
          if (stg_cur[i] != RANK_MAX) stg_next[i] = stg_cur[i] + RANK_W'(1);
        end else begin
          if (stg_cur[i] != '0) stg_next[i] = stg_cur[i] - RANK_W'(1);
        end
      end
    end
  end

  // Winner selection. A lookup that hits the staged index sees the staged
  // result. A strict compare keeps the lowest component on ties.
  always_comb begin
    sel_ranks = (stg_valid_q && (lookup_index == stg_index_q)) ?
                stg_next : tbl_q[lookup_index];
    best_rank = sel_ranks[0];
    win_sel   = '0;
    win_pred  = lookup_preds[0];
    for (int i = 1; i < NUM_PRED; i++) begin
      if (sel_ranks[i] > best_rank) begin
        best_rank = sel_ranks[i];
        win_sel   = SEL_W'(i);
        win_pred  = lookup_preds[i];
      end
    end
    choice     = 1'b0;
    choice_sel = '0;
    if (state_q == ST_RUN) begin
      choice     = win_pred;
      choice_sel = win_sel;
    end
  end

  assign ready = ready_q;

  // Control FSM. It walks the init pointer, then accepts updates into the stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_INIT;
      ptr_q         <= '0;
      ready_q       <= 1'b0;
      stg_valid_q   <= 1'b0;
      stg_index_q   <= '0;
      stg_preds_q   <= '0;
      stg_outcome_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          stg_valid_q <= 1'b0;
          ptr_q       <= ptr_q + INDEX_W'(1);
          if (ptr_q == PTR_LAST) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          stg_valid_q <= upd_valid;
          if (upd_valid) begin
            stg_index_q   <= upd_index;
            stg_preds_q   <= upd_preds;
            stg_outcome_q <= upd_outcome;
          end
        end
      endcase
    end
  end

  // Table writes are init fill or a staged update. Nothing is written on a
  // reset edge, so a pending update is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_q == ST_INIT) begin
        tbl_q[ptr_q] <= ENTRY_MID;
      end else if (stg_valid_q) begin
        tbl_q[stg_index_q] <= stg_next;
      end
    end
  end

endmodule

// File: tb/tb_tournament_selector.sv
// tb_tournament_selector: directed vectors for the default configuration
// (3 components, 2-bit ranks, 64 entries) and for a 5/3/3 configuration.
module tb_tournament_selector;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [5:0] lookup_index;
  logic [2:0] lookup_preds;
  logic       choice;
  logic [1:0] choice_sel;
  logic       ready;
  logic       upd_valid;
  logic [5:0] upd_index;
  logic [2:0] upd_preds;
  logic       upd_outcome;

  logic       r5;
  logic [2:0] li5;
  logic [4:0] lp5;
  logic       ch5;
  logic [2:0] cs5;
  logic       rdy5;
  logic       uv5;
  logic [2:0] ui5;
  logic [4:0] up5;
  logic       uo5;

  tournament_selector u_dut (
    .clk(clk), .reset(reset),
    .lookup_index(lookup_index), .lookup_preds(lookup_preds),
    .choice(choice), .choice_sel(choice_sel), .ready(ready),
    .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_preds(upd_preds), .upd_outcome(upd_outcome)
  );

  tournament_selector #(.NUM_PRED(5), .RANK_W(3), .INDEX_W(3)) u_dut5 (
    .clk(clk), .reset(r5),
    .lookup_index(li5), .lookup_preds(lp5),
    .choice(ch5), .choice_sel(cs5), .ready(rdy5),
    .upd_valid(uv5), .upd_index(ui5),
    .upd_preds(up5), .upd_outcome(uo5)
  );

  int total = 0;
  int bad   = 0;
  int n;

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [5:0] idx, input logic [2:0] p, input logic o);
    upd_valid   = 1'b1;
    upd_index   = idx;
    upd_preds   = p;
    upd_outcome = o;
    tick();
    upd_valid   = 1'b0;
  endtask

  task automatic look(input logic [5:0] idx, input logic [2:0] p);
    lookup_index = idx;
    lookup_preds = p;
    #1;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; upd_valid = 1'b0; upd_index = '0; upd_preds = '0; upd_outcome = 1'b0;
    lookup_index = '0; lookup_preds = 3'b111;
    r5 = 1'b0; uv5 = 1'b0; ui5 = '0; up5 = '0; uo5 = 1'b0; li5 = '0; lp5 = '0;

    // Reset held for 3 cycles
    repeat (3) tick();
    check("rst_ready", ready, 0);
    check("rst_choice", choice, 0);
    check("rst_sel", choice_sel, 0);

    // Release reset with an update request that must be dropped during init
    reset = 1'b1;
    upd_valid = 1'b1; upd_index = 6'd5; upd_preds = 3'b001; upd_outcome = 1'b1;
    tick();
    check("init_stage_idle", u_dut.stg_valid_q, 0);
    check("init_ready", ready, 0);
    check("init_choice", choice, 0);
    wait_ready(n);
    upd_valid = 1'b0;
    check("init_len", n + 1, 64);
    check("init_mid_0", u_dut.tbl_q[0], 6'b101010);
    check("init_mid_63", u_dut.tbl_q[63], 6'b101010);

    // Tie at MID resolves to component 0
    look(6'd5, 3'b110);
    check("tie_choice", choice, 0);
    check("tie_sel", choice_sel, 0);

    // Training index 7, ranks become [0,3,0]
    upd(6'd7, 3'b010, 1'b1);
    upd(6'd7, 3'b010, 1'b1);
    upd(6'd7, 3'b010, 1'b1);
    tick();
    check("train_tbl", u_dut.tbl_q[7], 6'b001100);
    look(6'd7, 3'b101);
    check("train_sel", choice_sel, 1);
    check("train_choice", choice, 0);
    upd(6'd7, 3'b010, 1'b1);
    tick();
    check("sat_tbl", u_dut.tbl_q[7], 6'b001100);

    // No discrimination leaves the entry unchanged
    upd(6'd11, 3'b111, 1'b1);
    upd(6'd11, 3'b000, 1'b1);
    tick();
    check("nodisc_tbl", u_dut.tbl_q[11], 6'b101010);
    look(6'd11, 3'b010);
    check("nodisc_sel", choice_sel, 0);

    // Bypass and back-to-back updates on index 9: [2,2,2] -> [1,1,3] -> [0,0,3]
    upd_valid = 1'b1; upd_index = 6'd9; upd_preds = 3'b100; upd_outcome = 1'b1;
    tick();
    look(6'd9, 3'b100);
    check("byp1_sel", choice_sel, 2);
    check("byp1_choice", choice, 1);
    tick();
    upd_valid = 1'b0;
    look(6'd9, 3'b011);
    check("byp2_sel", choice_sel, 2);
    check("byp2_choice", choice, 0);
    tick();
    check("b2b_tbl", u_dut.tbl_q[9], 6'b110000);
    look(6'd9, 3'b100);
    check("b2b_sel", choice_sel, 2);
    check("b2b_choice", choice, 1);

    // A lookup in the same cycle as an update sees the pre-update ranks
    upd_valid = 1'b1; upd_index = 6'd20; upd_preds = 3'b010; upd_outcome = 1'b1;
    look(6'd20, 3'b010);
    check("same_cyc_sel", choice_sel, 0);
    check("same_cyc_choice", choice, 0);
    tick();
    upd_valid = 1'b0;
    look(6'd20, 3'b010);
    check("next_cyc_sel", choice_sel, 1);
    check("next_cyc_choice", choice, 1);
    tick();

    // Reset while the stage is valid drops the pending write
    upd(6'd13, 3'b001, 1'b1);
    check("pend_stage", u_dut.stg_valid_q, 1);
    reset = 1'b0;
    look(6'd13, 3'b111);
    tick();
    check("drop_tbl", u_dut.tbl_q[13], 6'b101010);
    check("drop_ready", ready, 0);
    check("drop_stage", u_dut.stg_valid_q, 0);
    check("drop_choice", choice, 0);
    tick();
    reset = 1'b1;
    wait_ready(n);
    check("reinit_len", n, 64);
    check("reinit_tbl7", u_dut.tbl_q[7], 6'b101010);
    check("reinit_tbl9", u_dut.tbl_q[9], 6'b101010);

    // Five components, 3-bit ranks, 8 entries
    r5 = 1'b1;
    n = 0;
    while (!rdy5 && n < 200) begin
      tick();
      n++;
    end
    check("p5_init_len", n, 8);
    check("p5_mid", u_dut5.tbl_q[2], 15'h4924);
    li5 = 3'd3; lp5 = 5'b00001; #1;
    check("p5_tie_sel", cs5, 0);
    check("p5_tie_choice", ch5, 1);
    uv5 = 1'b1; ui5 = 3'd2; up5 = 5'b10000; uo5 = 1'b1;
    tick();
    tick();
    uv5 = 1'b0;
    tick();
    check("p5_tbl", u_dut5.tbl_q[2], 15'h6492);
    li5 = 3'd2; lp5 = 5'b10000; #1;
    check("p5_sel", cs5, 4);
    check("p5_choice", ch5, 1);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
